// File: rtl/gate_op_scheduler.sv
// Shares one registered bitwise gate unit (AND/OR/XOR/NAND) among four requesters.
// Define GATE_SCHED_RR_EN for round-robin arbitration; otherwise lowest index wins.
module gate_op_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req_valid,
  output logic [3:0]           req_ready,
  input  logic [4*WIDTH-1:0]   req_a,
  input  logic [4*WIDTH-1:0]   req_b,
  input  logic [7:0]           req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_y,
  output logic [1:0]           rsp_id,
  output logic                 busy,
  output logic [15:0]          done_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       r_last_grant;
  logic [WIDTH-1:0] r_a_p0;
  logic [WIDTH-1:0] r_b_p0;
  logic [1:0]       r_op_p0;
  logic [1:0]       r_id_p0;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_y;
  logic [1:0]       r_rsp_id;
  logic             r_busy;
  logic [15:0]      r_done_count;

  logic             w_any;
  logic             w_take;
  logic [1:0]       w_win;
  logic [3:0]       w_grant;
  logic [1:0]       w_next;

  function automatic logic [WIDTH-1:0] gate_eval(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   gate_eval = a & b;
      2'b01:   gate_eval = a | b;
      2'b10:   gate_eval = a ^ b;
      default: gate_eval = ~(a & b);
    endcase
  endfunction

  // Descending scan so the last hit is the highest-priority valid index.
  always_comb begin
    w_win = 2'd0;
    w_any = |req_valid;
`ifdef GATE_SCHED_RR_EN
    for (int k = 4; k >= 1; k--) begin
      if (req_valid[r_last_grant + 2'(k)]) w_win = r_last_grant + 2'(k);
    end
`else
    for (int k = 3; k >= 0; k--) begin
      if (req_valid[k]) w_win = 2'(k);
    end
`endif
    w_take  = (r_state == S_IDLE) && w_any && !rst;
    w_grant = 4'b0000;
    if (w_take) w_grant[w_win] = 1'b1;
  end

  assign req_ready = w_grant;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_EXEC;
      S_EXEC:  w_next = S_HOLD;
      S_HOLD:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Stage p0: operands of the granted requester captured at the handshake.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_a_p0  <= req_a[w_win*WIDTH +: WIDTH];
      r_b_p0  <= req_b[w_win*WIDTH +: WIDTH];
      r_op_p0 <= req_op[2*w_win +: 2];
      r_id_p0 <= w_win;
    end
  end

  // Stage p1: evaluated result presented and held until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 2'd3;
      r_rsp_valid  <= 1'b0;
      r_rsp_y      <= '0;
      r_rsp_id     <= 2'd0;
      r_busy       <= 1'b0;
      r_done_count <= 16'd0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      if (w_take) r_last_grant <= w_win;
      if (r_state == S_EXEC) begin
        r_rsp_valid <= 1'b1;
        r_rsp_y     <= gate_eval(r_op_p0, r_a_p0, r_b_p0);
        r_rsp_id    <= r_id_p0;
      end
      if (r_state == S_HOLD && rsp_ready) begin
        r_rsp_valid  <= 1'b0;
        r_done_count <= r_done_count + 16'd1;
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_y      = r_rsp_y;
  assign rsp_id     = r_rsp_id;
  assign busy       = r_busy;
  assign done_count = r_done_count;

endmodule

// File: tb/tb_gate_op_scheduler.sv
// Directed plus randomized bench for gate_op_scheduler against a transaction-level reference model.
module tb_gate_op_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_y;
  logic [1:0]  rsp_id;
  logic        busy;
  logic [15:0] done_count;

  int n_vec = 0;
  int n_err = 0;
  int model_last = 3;
  int model_cnt = 0;

  gate_op_scheduler #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_id(rsp_id),
    .busy(busy), .done_count(done_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] m);
`ifdef GATE_SCHED_RR_EN
    for (int k = 1; k <= 4; k++) begin
      if (m[(model_last + k) % 4]) return (model_last + k) % 4;
    end
`else
    for (int k = 0; k < 4; k++) begin
      if (m[k]) return k;
    end
`endif
    return 0;
  endfunction

  function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    if (op == 2'd0) return a & b;
    if (op == 2'd1) return a | b;
    if (op == 2'd2) return a ^ b;
    return ~(a & b);
  endfunction

  // Starts in IDLE at a negedge; returns at a negedge back in IDLE.
  task automatic txn(input logic [3:0] mask, input logic [31:0] av, input logic [31:0] bv,
                     input logic [7:0] ov, input int stall, input bit abort, output int g);
    logic [7:0] ey;
    req_valid = mask; req_a = av; req_b = bv; req_op = ov;
    rsp_ready = (stall == 0);
    #1;
    g  = pick(mask);
    ey = ref_op(ov[2*g +: 2], av[8*g +: 8], bv[8*g +: 8]);
    chk("grant", 32'(req_ready), 32'(4'b0001 << g));
    chk("busy_idle", 32'(busy), 32'd0);
    model_last = g;
    @(posedge clk); @(negedge clk);
    req_a = $urandom; req_b = $urandom; req_op = 8'($urandom);
    chk("exec_ready", 32'(req_ready), 32'd0);
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_y", 32'(rsp_y), 32'(ey));
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("rsp_ready_low", 32'(req_ready), 32'd0);
    chk("cnt_before", 32'(done_count), 32'(model_cnt));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_y", 32'(rsp_y), 32'(ey));
      chk("hold_id", 32'(rsp_id), 32'(g));
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    if (abort) begin
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_cnt", 32'(done_count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      model_last = 3;
      model_cnt = 0;
    end else begin
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      model_cnt = (model_cnt + 1) & 16'hFFFF;
      chk("cnt_after", 32'(done_count), 32'(model_cnt));
      chk("done_valid", 32'(rsp_valid), 32'd0);
      chk("done_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int g;
    logic [3:0] m;
    rst = 1'b1; req_valid = 4'hF; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("rst_cycle_ready", 32'(req_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_y", 32'(rsp_y), 32'd0);
    chk("reset_id", 32'(rsp_id), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cnt", 32'(done_count), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    // Single request: 0xF0 AND 0x3C
    txn(4'b0001, 32'h0000_00F0, 32'h0000_003C, 8'h00, 0, 1'b0, g);
    chk("single_cnt", 32'(done_count), 32'd1);

    // All opcodes on requester 2
    for (int op = 0; op < 4; op++) begin
      txn(4'b0100, 32'h00AA_0000, 32'h000F_0000, 8'(op << 4), 0, 1'b0, g);
      chk("op_id", 32'(g), 32'd2);
    end

    // Two random transactions bring the count to 7
    for (int i = 0; i < 2; i++) begin
      m = 4'($urandom_range(1, 15));
      txn(m, $urandom, $urandom, 8'($urandom), 0, 1'b0, g);
    end

    // Reset while holding a result
    txn(4'b1111, $urandom, $urandom, 8'($urandom), 1, 1'b1, g);

    // Arbitration order with all requesters held
    for (int i = 0; i < 6; i++) begin
      txn(4'b1111, $urandom, $urandom, 8'($urandom), 0, 1'b0, g);
`ifdef GATE_SCHED_RR_EN
      chk("rr_order", 32'(g), 32'(i % 4));
`else
      chk("fixed_order", 32'(g), 32'd0);
`endif
    end

    // Backpressure
    txn(4'b1010, $urandom, $urandom, 8'($urandom), 5, 1'b0, g);

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      m = 4'($urandom_range(1, 15));
      txn(m, $urandom, $urandom, 8'($urandom), $urandom_range(0, 2), 1'b0, g);
    end

    // No requests: stays idle
    req_valid = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_ready", 32'(req_ready), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // Counter wrap
    force dut.r_done_count = 16'hFFFF;
    #1;
    release dut.r_done_count;
    model_cnt = 16'hFFFF;
    chk("preload_cnt", 32'(done_count), 32'h0000_FFFF);
    txn(4'b0001, $urandom, $urandom, 8'($urandom), 0, 1'b0, g);
    chk("wrap_cnt", 32'(done_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
